mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage data-memory access unit. Consumes the memory control fields that the main decoder produces:
//  load, DMWr, EXT_MEM and dm_choose. Drives a req/ack data-memory bus with byte enables and lane-replicated
//  write data, then sign/zero-extends load data for WB. Stalls the pipeline while an access is outstanding
//  and flags misaligned accesses (AdEL/AdES) instead of issuing them.
// PARAMETERS
//  TIMEOUT   16  max cycles mem_req may wait for mem_ack before bus_err (>=1)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-low reset (0 = reset)
//  in_valid   in   1   EX/MEM slot holds an instruction
//  in_ready   out  1   unit can accept; 1 only in IDLE
//  load       in   1   memory read
//  DMWr       in   1   memory write
//  EXT_MEM    in   3   000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw (others: treat as lw)
//  dm_choose  in   2   00 sb, 01 sh, 10 sw (11: treat as sw)
//  addr       in   32  byte address from ALU
//  wdata      in   32  store data (rt)
//  mem_req    out  1   bus request, held until mem_ack or timeout
//  mem_we     out  1   1 = write
//  mem_addr   out  32  {addr[31:2],2'b00}
//  mem_be     out  4   byte enables, bit i = byte lane i (little-endian)
//  mem_wdata  out  32  lane-replicated store data
//  mem_ack    in   1   bus completes access this cycle
//  mem_rdata  in   32  read word, valid when mem_ack=1
//  out_valid  out  1   one-cycle pulse: access (or non-access) finished
//  out_rdata  out  32  extended load result; 0 for stores/errors/non-memory ops
//  adel       out  1   load address error, with out_valid
//  ades       out  1   store address error, with out_valid
//  bus_err    out  1   timeout, with out_valid
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1; mem_req, mem_we, mem_be, out_valid, adel, ades, bus_err = 0; mem_addr, mem_wdata, out_rdata = 0.
//  FSM IDLE -> REQ -> RESP -> IDLE. A handshake occurs when in_valid & in_ready; all inputs are captured into registers at that edge.
//  IDLE, handshake:
//   - neither load nor DMWr: go to RESP; no bus activity; out_valid next cycle with out_rdata=0.
//   - load=1 takes priority over DMWr=1 when both are set.
//   - misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. Go to RESP; no mem_req;
//     adel (load) or ades (store) pulses with out_valid.
//   - aligned: go to REQ. mem_req=1 from the next cycle.
//  REQ:
//   - mem_req, mem_we, mem_addr, mem_be and mem_wdata stay stable until mem_ack.
//   - mem_ack may arrive in the first REQ cycle.
//   - On mem_ack, capture mem_rdata and go to RESP; mem_req falls the following cycle.
//   - The wait counter increments every REQ cycle without ack. If it reaches TIMEOUT, drop mem_req,
//     go to RESP, and set bus_err.
//  RESP: out_valid=1 for exactly one cycle, with out_rdata and flags; next state IDLE.
//   - in_ready=0 in REQ and RESP.
//   - Access latency = 1 + ack wait cycles + 1.
//  Store lanes (s = addr[1:0]):
//   - sb: mem_be = 4'b0001 << s; mem_wdata = {4{wdata[7:0]}}.
//   - sh: mem_be = addr[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{wdata[15:0]}}.
//   - sw: mem_be = 4'b1111; mem_wdata = wdata.
//   - Loads: mem_be = 4'b1111; mem_we = 0.
//  Load extract:
//   - b = mem_rdata[8*s+:8]; h = mem_rdata[16*addr[1]+:16].
//   - lb = {{24{b[7]}},b}; lbu = {24'b0,b}; lh = {{16{h[15]}},h}; lhu = {16'b0,h}; lw = mem_rdata.
//  Reset asserted mid-access: outputs go to reset values immediately (mem_req drops asynchronously).
//  The in-flight access is abandoned; a late mem_ack after reset is ignored in IDLE.
//  mem_ack while not in REQ: ignored.
// TESTING
//  1. sb, addr=0x1003, wdata=0x000000AB, ack first cycle -> mem_be=1000, mem_wdata=0xABABABAB, mem_we=1;
//     out_valid 2 cycles after accept, out_rdata=0.
//  2. lh, addr=0x2002, mem_rdata=0x80011234 -> out_rdata=0xFFFF8001; same with lhu -> 0x00008001;
//     lb at 0x2001 -> 0x00000012.
//  3. lw, addr=0x1002 -> mem_req never 1; out_valid with adel=1 one cycle after accept;
//     sh at 0x0001 -> ades=1.
//  4. sw, mem_ack delayed 3 cycles -> mem_req high 4 cycles with stable addr/be/wdata;
//     in_ready=0 throughout; out_valid 1 cycle after ack.
//  5. TIMEOUT=16, lw, no ack -> mem_req high 16 cycles, then drops;
//     out_valid with bus_err=1, out_rdata=0.
//  6. rst=0 during REQ wait -> mem_req=0 at once; after release in_ready=1;
//     a stray mem_ack produces no out_valid.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues req/ack bus accesses with byte
// enables and lane-replicated store data, extends load data for writeback,
// and reports misaligned accesses and bus timeouts instead of hanging.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        load,
  input  logic        DMWr,
  input  logic [2:0]  EXT_MEM,
  input  logic [1:0]  dm_choose,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_rdata,
  output logic        adel,
  output logic        ades,
  output logic        bus_err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] wcnt;
  logic          ld_q;
  logic [2:0]    ext_q;
  logic [1:0]    ofs_q;

  logic          hs, is_ld, is_st, is_half, is_word, mis;
  logic [3:0]    be_st;
  logic [31:0]   wd_st, ld_ext;
  logic [7:0]    b;
  logic [15:0]   h;

  assign hs        = in_valid & in_ready;
  assign in_ready  = (state == IDLE);
  assign mem_req   = (state == REQ);
  assign out_valid = (state == RESP);

  // Decode access size and alignment; load wins when both load and DMWr are set.
  always_comb begin
    is_ld   = load;
    is_st   = ~load & DMWr;
    is_half = 1'b0;
    is_word = 1'b0;
    if (is_ld) begin
      is_half = (EXT_MEM == 3'b010) || (EXT_MEM == 3'b011);
      is_word = (EXT_MEM[2] == 1'b1) || (EXT_MEM[2:1] == 2'b11);
    end else begin
      is_half = (dm_choose == 2'b01);
      is_word = dm_choose[1];
    end
    mis = (is_ld | is_st) &
          ((is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00)));
  end

  // Store byte enables and lane replication.
  always_comb begin
    be_st = 4'b1111;
    wd_st = wdata;
    if (dm_choose == 2'b00) begin
      be_st = 4'b0001 << addr[1:0];
      wd_st = {4{wdata[7:0]}};
    end else if (dm_choose == 2'b01) begin
      be_st = addr[1] ? 4'b1100 : 4'b0011;
      wd_st = {2{wdata[15:0]}};
    end
  end

  // Load lane extraction and sign/zero extension from the captured offset.
  always_comb begin
    b = mem_rdata[{ofs_q, 3'b000} +: 8];
    h = mem_rdata[{ofs_q[1], 4'b0000} +: 16];
    case (ext_q)
      3'b000:  ld_ext = {{24{b[7]}}, b};
      3'b001:  ld_ext = {24'b0, b};
      3'b010:  ld_ext = {{16{h[15]}}, h};
      3'b011:  ld_ext = {16'b0, h};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Next-state logic: aligned accesses go through REQ, everything else straight to RESP.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (hs) state_nx = ((is_ld | is_st) & ~mis) ? REQ : RESP;
      REQ:  if (mem_ack || (wcnt == CW'(TIMEOUT - 1))) state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Capture the access at handshake, track ack wait, and hold results for the RESP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      ld_q      <= 1'b0;
      ext_q     <= '0;
      ofs_q     <= '0;
      wcnt      <= '0;
      out_rdata <= '0;
      adel      <= 1'b0;
      ades      <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          mem_we    <= is_st;
          mem_addr  <= {addr[31:2], 2'b00};
          mem_be    <= is_st ? be_st : 4'b1111;
          mem_wdata <= is_st ? wd_st : 32'h0;
          ld_q      <= is_ld;
          ext_q     <= EXT_MEM;
          ofs_q     <= addr[1:0];
          wcnt      <= '0;
          adel      <= is_ld & mis;
          ades      <= is_st & mis;
          bus_err   <= 1'b0;
          out_rdata <= '0;
        end
        REQ: begin
          if (mem_ack) begin
            out_rdata <= ld_q ? ld_ext : 32'h0;
          end else begin
            wcnt <= wcnt + CW'(1);
            if (wcnt == CW'(TIMEOUT - 1)) bus_err <= 1'b1;
          end
        end
        RESP: begin
          out_rdata <= '0;
          adel      <= 1'b0;
          ades      <= 1'b0;
          bus_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit: a driver issues accesses and
// queues expected bus transactions and responses; a bus responder acks after a
// chosen delay and checks request fields; a monitor checks each out_valid pulse.
module tb_mem_access_unit;
  localparam int TO = 16;

  logic clk = 0, rst = 0;
  logic in_valid = 0, in_ready, load = 0, DMWr = 0;
  logic [2:0] EXT_MEM = 0;
  logic [1:0] dm_choose = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic mem_req, mem_we, mem_ack = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0, out_rdata;
  logic [3:0] mem_be;
  logic out_valid, adel, ades, bus_err;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .load(load), .DMWr(DMWr), .EXT_MEM(EXT_MEM), .dm_choose(dm_choose),
    .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_rdata(out_rdata), .adel(adel), .ades(ades), .bus_err(bus_err));

  always #5 clk = ~clk;

  typedef struct {logic [31:0] rdata; bit adel, ades, berr; int lat, acc;} resp_t;
  typedef struct {bit we; logic [31:0] addr, wdata, rdata; logic [3:0] be; int delay;} bus_t;

  resp_t sbq[$];
  bus_t  busq[$];
  int errors = 0, checks = 0, cyc = 0;
  bit bus_off = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model straight from the access rules: size, alignment, lanes, extension, latency.
  function automatic void model(input bit ld, wr, input logic [2:0] ext, input logic [1:0] dmc,
                                input logic [31:0] a, wd, rd, input int d,
                                output resp_t r, output bus_t b, output bit acc);
    int size, off;
    bit isld, isst, mis;
    logic [31:0] v, mask;
    isld = ld;
    isst = !ld && wr;
    if (isld) size = (ext <= 1) ? 1 : (ext <= 3) ? 2 : 4;
    else      size = (dmc == 0) ? 1 : (dmc == 1) ? 2 : 4;
    mis = (isld || isst) && ((int'(a[1:0]) % size) != 0);
    acc = (isld || isst) && !mis;
    b.we = isst; b.addr = a & 32'hFFFF_FFFC; b.rdata = rd; b.delay = d;
    b.be = 4'hF; b.wdata = wd;
    if (isst && size == 1) begin
      b.be = 4'b0001 << a[1:0]; b.wdata = {24'b0, wd[7:0]} * 32'h0101_0101;
    end else if (isst && size == 2) begin
      b.be = a[1] ? 4'b1100 : 4'b0011; b.wdata = {16'b0, wd[15:0]} * 32'h0001_0001;
    end
    r.adel = isld && mis; r.ades = isst && mis;
    r.berr = acc && d >= TO;
    r.rdata = 0;
    if (isld && acc && d < TO) begin
      off = (size == 1) ? int'(a[1:0]) : (size == 2) ? (a[1] ? 2 : 0) : 0;
      v = rd >> (8 * off);
      if (size < 4) begin
        mask = (32'h1 << (8 * size)) - 1;
        v = v & mask;
        if ((ext == 0 || ext == 2) && v[8*size-1]) v = v | ~mask;
      end
      r.rdata = v;
    end
    r.lat = !acc ? 1 : (d >= TO ? 1 + TO : d + 2);
  endfunction

  task automatic issue(input bit ld, wr, input logic [2:0] ext, input logic [1:0] dmc,
                       input logic [31:0] a, wd, rd, input int d);
    resp_t r; bus_t b; bit acc; int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL in_ready_wait: got 0 expected 1 within 200 cycles");
      return;
    end
    load = ld; DMWr = wr; EXT_MEM = ext; dm_choose = dmc; addr = a; wdata = wd;
    in_valid = 1;
    model(ld, wr, ext, dmc, a, wd, rd, d, r, b, acc);
    r.acc = cyc;
    sbq.push_back(r);
    if (acc) busq.push_back(b);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  // Bus responder: checks request fields and their stability, acks after the chosen delay.
  initial begin
    bus_t cur; bit active = 0; int ncyc = 0;
    forever begin
      @(negedge clk);
      if (!bus_off) begin
        mem_ack = 0;
        mem_rdata = $urandom;
        if (mem_req) begin
          if (!active) begin
            if (busq.size() == 0) begin
              chk("unexpected_mem_req", 1, 0);
              active = 1; ncyc = 0; cur.delay = 1000;
              cur.we = mem_we; cur.addr = mem_addr; cur.be = mem_be; cur.wdata = mem_wdata;
            end else begin
              cur = busq.pop_front(); active = 1; ncyc = 0;
            end
          end
          chk("mem_we", mem_we, cur.we);
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_be", mem_be, cur.be);
          if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
          chk("in_ready_busy", in_ready, 0);
          if (ncyc == cur.delay) begin mem_ack = 1; mem_rdata = cur.rdata; end
          ncyc++;
        end else if (active) begin
          chk("req_cycles", ncyc, (cur.delay >= TO) ? TO : cur.delay + 1);
          active = 0;
        end
      end
    end
  end

  // Monitor: every out_valid pulse must match the oldest queued expectation.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && rst) begin
        if (sbq.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("out_rdata", out_rdata, e.rdata);
          chk("adel", adel, e.adel);
          chk("ades", ades, e.ades);
          chk("bus_err", bus_err, e.berr);
          chk("latency", cyc - e.acc, e.lat);
        end
      end
    end
  end

  initial begin
    int n, d, r, nv;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_out_rdata", out_rdata, 0);
    rst = 1;

    // Directed cases.
    issue(0, 1, 3'd0, 2'd0, 32'h1003, 32'h0000_00AB, 32'h0, 0);        // sb lane 3
    issue(1, 0, 3'd2, 2'd0, 32'h2002, 32'h0, 32'h8001_1234, 1);        // lh
    issue(1, 0, 3'd3, 2'd0, 32'h2002, 32'h0, 32'h8001_1234, 0);        // lhu
    issue(1, 0, 3'd0, 2'd0, 32'h2001, 32'h0, 32'h8001_1234, 2);        // lb
    issue(1, 0, 3'd4, 2'd0, 32'h1002, 32'h0, 32'h0, 0);                // lw misaligned
    issue(0, 1, 3'd0, 2'd1, 32'h0001, 32'h1234, 32'h0, 0);             // sh misaligned
    issue(0, 1, 3'd0, 2'd2, 32'h3000, 32'hDEAD_BEEF, 32'h0, 3);        // sw, ack delayed 3
    issue(1, 0, 3'd4, 2'd0, 32'h4000, 32'h0, 32'h1, 100);              // lw timeout
    issue(0, 0, 3'd0, 2'd0, 32'h5000, 32'h0, 32'h0, 0);                // no memory op
    issue(1, 1, 3'd1, 2'd0, 32'h6003, 32'h0, 32'hF0E0_D0C0, 0);        // both set: load wins
    issue(1, 0, 3'd4, 2'd0, 32'h7000, 32'h0, 32'hCAFE_F00D, TO - 1);   // ack in last allowed cycle

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      d = (r == 0) ? TO + 4 : $urandom_range(0, 4);
      n = $urandom_range(0, 3);
      issue(n[0], n[1], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int i = 0; i < 500 && (sbq.size() != 0 || busq.size() != 0); i++) @(negedge clk);
    chk("pending_resp", sbq.size(), 0);
    chk("pending_bus", busq.size(), 0);
    repeat (2) @(negedge clk);

    // Reset in the middle of an ack wait, then a stray ack.
    bus_off = 1;
    mem_ack = 0;
    @(negedge clk);
    load = 1; DMWr = 0; EXT_MEM = 3'd4; addr = 32'h40; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(negedge clk);
    chk("pre_rst_mem_req", mem_req, 1);
    #2 rst = 0;
    #1;
    chk("async_rst_mem_req", mem_req, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_mem_be", mem_be, 0);
    @(negedge clk) rst = 1;
    @(negedge clk) begin mem_ack = 1; mem_rdata = 32'h1234_5678; end
    @(negedge clk) mem_ack = 0;
    nv = 0;
    repeat (4) begin @(negedge clk); if (out_valid) nv++; end
    chk("stray_ack_out_valid", nv, 0);
    chk("post_rst_in_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
